// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the LED-matrix scan driver.
// Holds default geometry/timing, index-width helper and OFF levels.
package matrix_pkg;

    localparam int ROWS_DEF  = 8;
    localparam int COLS_DEF  = 16;
    localparam int DWELL_DEF = 64;
    localparam int BLANK_DEF = 2;

    // Pins are active-low: a 1 means row deselected / column dark.
    localparam logic ROW_OFF = 1'b1;
    localparam logic COL_OFF = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Row scan timebase: dwell counter, row index, blank flag, frame_tick.
// Ports: clk, rst_n in; row_o, blank_o, wrap_o (comb), frame_tick_o out.
module matrix_scan_timer
    import matrix_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int BLANK = BLANK_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [idx_w(ROWS)-1:0] row_o,
    output logic                   blank_o,
    output logic                   wrap_o,
    output logic                   frame_tick_o
);

    localparam int RW = idx_w(ROWS);
    localparam int DW = idx_w(DWELL);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [RW-1:0] row_q, row_d;
    logic          tick_q, tick_d;
    logic          last_dwell, last_row;

    always_comb begin
        last_dwell = (dwell_q == DW'(DWELL - 1));
        last_row   = (row_q == RW'(ROWS - 1));
        dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
        row_d      = row_q;
        if (last_dwell) begin
            row_d = last_row ? '0 : row_q + 1'b1;
        end
        // wrap_o is the last cycle of the frame; the tick is
        // registered so it lands together with the other outputs.
        wrap_o  = last_dwell && last_row;
        tick_d  = wrap_o;
        blank_o = int'(dwell_q) < BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
            row_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            row_q   <= row_d;
            tick_q  <= tick_d;
        end
    end

    assign row_o        = row_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/matrix_scanner.sv
// LED-matrix scan driver: framebuffer, pixel write, bulk clear, row scan.
// Ports: pix_* write port, clr_req/busy, swap_req/swap_ack, frame_tick,
// MATRIX_ROW/MATRIX_COL active-low pins.
// Build option: MATRIX_SCANNER_DOUBLE_BUFFER_EN adds front/back buffers.
module matrix_scanner
    import matrix_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int BLANK = BLANK_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_we,
    input  logic [idx_w(COLS)-1:0] pix_x,
    input  logic [idx_w(ROWS)-1:0] pix_y,
    input  logic                   pix_val,
    input  logic                   clr_req,
    input  logic                   swap_req,
    output logic                   busy,
    output logic                   frame_tick,
    output logic                   swap_ack,
    output logic [ROWS-1:0]        MATRIX_ROW,
    output logic [COLS-1:0]        MATRIX_COL
);

    localparam int YW = idx_w(ROWS);

`ifdef MATRIX_SCANNER_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    logic [COLS-1:0] fb_q [NBUF][ROWS];
    logic [COLS-1:0] fb_d [NBUF][ROWS];
    logic            busy_q, busy_d;
    logic [YW-1:0]   clr_row_q, clr_row_d;
    logic [ROWS-1:0] row_out_q, row_out_d;
    logic [COLS-1:0] col_q, col_d;
    logic            swap_ack_q, swap_ack_d;
    logic            front, back;
    logic            pix_ok;

    logic [YW-1:0]   scan_row;
    logic            blank, wrap;

    matrix_scan_timer #(
        .ROWS  (ROWS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .row_o        (scan_row),
        .blank_o      (blank),
        .wrap_o       (wrap),
        .frame_tick_o (frame_tick)
    );

`ifdef MATRIX_SCANNER_DOUBLE_BUFFER_EN
    logic sel_q, sel_d, pend_q, pend_d, swap;

    // Swap only at a frame boundary and never mid-clear, so a
    // partially cleared buffer is never shown.
    always_comb begin
        front      = sel_q;
        back       = ~sel_q;
        swap       = wrap && pend_q && !busy_q;
        sel_d      = swap ? ~sel_q : sel_q;
        pend_d     = swap ? swap_req : (pend_q | swap_req);
        swap_ack_d = swap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            pend_q <= pend_d;
        end
    end
`else
    logic swap_unused;

    assign swap_unused = swap_req;

    always_comb begin
        front      = 1'b0;
        back       = 1'b0;
        swap_ack_d = 1'b0;
    end
`endif

    always_comb begin
        fb_d      = fb_q;
        busy_d    = busy_q;
        clr_row_d = clr_row_q;
        pix_ok    = pix_we && (int'(pix_y) < ROWS) && (int'(pix_x) < COLS);
        if (busy_q) begin
            fb_d[back][clr_row_q] = '0;
            clr_row_d = clr_row_q + 1'b1;
            if (clr_row_q == YW'(ROWS - 1)) begin
                busy_d    = 1'b0;
                clr_row_d = '0;
            end
        end else if (clr_req) begin
            busy_d    = 1'b1;
            clr_row_d = '0;
        end else if (pix_ok) begin
            fb_d[back][pix_y][pix_x] = pix_val;
        end
        row_out_d = ~(ROWS'(1) << scan_row);
        col_d     = blank ? {COLS{COL_OFF}} : ~fb_q[front][scan_row];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBUF; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    fb_q[b][r] <= '0;
                end
            end
            busy_q     <= 1'b0;
            clr_row_q  <= '0;
            row_out_q  <= {ROWS{ROW_OFF}};
            col_q      <= {COLS{COL_OFF}};
            swap_ack_q <= 1'b0;
        end else begin
            fb_q       <= fb_d;
            busy_q     <= busy_d;
            clr_row_q  <= clr_row_d;
            row_out_q  <= row_out_d;
            col_q      <= col_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    assign busy       = busy_q;
    assign swap_ack   = swap_ack_q;
    assign MATRIX_ROW = row_out_q;
    assign MATRIX_COL = col_q;

endmodule
